// File: rtl/vc_rand_delay_queue.sv
module vc_rand_delay_queue #(
  parameter int unsigned p_msg_sz      = 67,
  parameter int unsigned p_num_entries = 4,
  parameter int unsigned p_max_delay   = 0,
  parameter logic [15:0] p_seed        = 16'hACE1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_val,
  output logic                              in_rdy,
  input  logic [p_msg_sz-1:0]               in_msg,
  output logic                              out_val,
  input  logic                              out_rdy,
  output logic [p_msg_sz-1:0]               out_msg,
  output logic [$clog2(p_num_entries):0]    occupancy
);

  localparam int unsigned AW = $clog2(p_num_entries);
  localparam int unsigned CW = AW + 1;
  localparam logic [8:0]  DELAY_MOD = 9'(p_max_delay + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND
  } state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       occ_q, occ_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [15:0]         lfsr_q;
  logic                lfsr_fb;
  logic [p_msg_sz-1:0] mem_q [p_num_entries];
  logic                enq, deq;
  logic [7:0]          draw;

  assign in_rdy    = (occ_q != CW'(p_num_entries));
  assign enq       = in_val && in_rdy;
  assign deq       = out_val && out_rdy;
  assign out_val   = (state_q == SEND);
  assign out_msg   = mem_q[rd_ptr_q];
  assign occupancy = occ_q;

  // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign draw    = 8'({1'b0, lfsr_q[7:0]} % DELAY_MOD);

  always_comb begin
    occ_d = occ_q;
    case ({enq, deq})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < p_num_entries; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      lfsr_q   <= p_seed;
    end else begin
      if (enq) begin
        mem_q[wr_ptr_q] <= in_msg;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (deq) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      occ_q  <= occ_d;
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A zero draw skips WAIT entirely, so the counter is only ever loaded with d >= 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (occ_q != '0) begin
          if (draw == 8'd0) begin
            state_d = SEND;
          end else begin
            cnt_d   = draw;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_rdy) begin
          if (occ_d != '0) begin
            if (draw != 8'd0) begin
              cnt_d   = draw;
              state_d = WAIT;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vc_rand_delay_queue.sv
module tb_vc_rand_delay_queue;

  localparam int unsigned W = 32;

  logic         clk;
  logic         reset;

  logic         in_val0, in_rdy0, out_val0, out_rdy0;
  logic [W-1:0] in_msg0, out_msg0;
  logic [2:0]   occ0;

  logic         in_val3, in_rdy3, out_val3, out_rdy3;
  logic [W-1:0] in_msg3, out_msg3;
  logic [2:0]   occ3;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] sb0[$];
  logic [W-1:0] sb3[$];

  vc_rand_delay_queue #(
    .p_msg_sz      (W),
    .p_num_entries (4),
    .p_max_delay   (0),
    .p_seed        (16'hACE1)
  ) dut0 (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in_val0),
    .in_rdy    (in_rdy0),
    .in_msg    (in_msg0),
    .out_val   (out_val0),
    .out_rdy   (out_rdy0),
    .out_msg   (out_msg0),
    .occupancy (occ0)
  );

  vc_rand_delay_queue #(
    .p_msg_sz      (W),
    .p_num_entries (4),
    .p_max_delay   (3),
    .p_seed        (16'hACE1)
  ) dut3 (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in_val3),
    .in_rdy    (in_rdy3),
    .in_msg    (in_msg3),
    .out_val   (out_val3),
    .out_rdy   (out_rdy3),
    .out_msg   (out_msg3),
    .occupancy (occ3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({out_val0, in_rdy0, occ0, out_msg0} !== {1'b0, 1'b1, 3'd0, 32'd0}) begin
      failures++;
      $display("FAIL reset_dut0 got val=%0b rdy=%0b occ=%0d msg=%h exp val=0 rdy=1 occ=0 msg=0",
               out_val0, in_rdy0, occ0, out_msg0);
    end
    checks++;
    if ({out_val3, in_rdy3, occ3, out_msg3} !== {1'b0, 1'b1, 3'd0, 32'd0}) begin
      failures++;
      $display("FAIL reset_dut3 got val=%0b rdy=%0b occ=%0d msg=%h exp val=0 rdy=1 occ=0 msg=0",
               out_val3, in_rdy3, occ3, out_msg3);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_val0, in_rdy0, occ0} !== {1'b0, 1'b1, 3'd0}) begin
      failures++;
      $display("FAIL reset_idle got val=%0b rdy=%0b occ=%0d exp val=0 rdy=1 occ=0",
               out_val0, in_rdy0, occ0);
    end
  endtask

  task automatic test_single;
    logic [W-1:0] exp;
    @(negedge clk);
    in_val0  = 1'b1;
    in_msg0  = 32'h0000_1234;
    out_rdy0 = 1'b1;
    sb0.push_back(in_msg0);
    @(negedge clk);
    in_val0 = 1'b0;
    checks++;
    if ({out_val0, occ0} !== {1'b0, 3'd1}) begin
      failures++;
      $display("FAIL single_after_enq got val=%0b occ=%0d exp val=0 occ=1", out_val0, occ0);
    end
    @(negedge clk);
    checks++;
    if (out_val0 !== 1'b1 || sb0.size() == 0) begin
      failures++;
      $display("FAIL single_offer got val=%0b exp val=1", out_val0);
    end else begin
      exp = sb0.pop_front();
      if (out_msg0 !== exp) begin
        failures++;
        $display("FAIL single_msg got=%h exp=%h", out_msg0, exp);
      end
    end
    @(negedge clk);
    checks++;
    if ({out_val0, occ0} !== {1'b0, 3'd0}) begin
      failures++;
      $display("FAIL single_drained got val=%0b occ=%0d exp val=0 occ=0", out_val0, occ0);
    end
  endtask

  task automatic test_fill;
    int           msg      = 1;
    int           accepted = 0;
    logic         fire     = 1'b0;
    logic [W-1:0] exp;
    out_rdy0 = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (fire) msg++;
      in_msg0 = W'(msg);
      in_val0 = (msg <= 5);
      fire    = in_val0 && in_rdy0;
      if (fire) begin
        sb0.push_back(in_msg0);
        accepted++;
      end
    end
    checks++;
    if (accepted != 4 || in_rdy0 !== 1'b0 || occ0 !== 3'd4) begin
      failures++;
      $display("FAIL fill_full got acc=%0d rdy=%0b occ=%0d exp acc=4 rdy=0 occ=4",
               accepted, in_rdy0, occ0);
    end
    out_rdy0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (out_val0 !== 1'b1 || sb0.size() == 0) begin
        failures++;
        $display("FAIL fill_consec%0d got val=%0b sb=%0d exp val=1", i, out_val0, sb0.size());
      end else begin
        exp = sb0.pop_front();
        if (out_msg0 !== exp) begin
          failures++;
          $display("FAIL fill_order%0d got=%h exp=%h", i, out_msg0, exp);
        end
      end
      if (fire) msg++;
      in_msg0 = W'(msg);
      in_val0 = (msg <= 5);
      fire    = in_val0 && in_rdy0;
      if (fire) sb0.push_back(in_msg0);
    end
    @(negedge clk);
    in_val0 = 1'b0;
    checks++;
    if ({out_val0, occ0, in_rdy0} !== {1'b0, 3'd0, 1'b1} || sb0.size() != 0) begin
      failures++;
      $display("FAIL fill_end got val=%0b occ=%0d rdy=%0b sb=%0d exp val=0 occ=0 rdy=1 sb=0",
               out_val0, occ0, in_rdy0, sb0.size());
    end
    out_rdy0 = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [W-1:0] exp;
    @(negedge clk);
    out_rdy0 = 1'b0;
    in_val0  = 1'b1;
    in_msg0  = 32'h55AA_0F0F;
    sb0.push_back(in_msg0);
    @(negedge clk);
    in_val0 = 1'b0;
    in_msg0 = 32'hDEAD_BEEF;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_val0 !== 1'b1 || occ0 !== 3'd1 || sb0.size() == 0 || out_msg0 !== sb0[0]) begin
        failures++;
        $display("FAIL bp_hold%0d got val=%0b occ=%0d msg=%h exp val=1 occ=1 msg=55aa0f0f",
                 i, out_val0, occ0, out_msg0);
      end
      @(negedge clk);
    end
    out_rdy0 = 1'b1;
    checks++;
    if (sb0.size() == 0 || out_val0 !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got val=%0b exp val=1", out_val0);
    end else begin
      exp = sb0.pop_front();
      if (out_msg0 !== exp) begin
        failures++;
        $display("FAIL bp_msg got=%h exp=%h", out_msg0, exp);
      end
    end
    @(negedge clk);
    out_rdy0 = 1'b0;
    checks++;
    if ({out_val0, occ0} !== {1'b0, 3'd0}) begin
      failures++;
      $display("FAIL bp_drained got val=%0b occ=%0d exp val=0 occ=0", out_val0, occ0);
    end
  endtask

  task automatic test_random;
    int           sent = 0, recv = 0, w = 0, wt;
    logic         idle_start = 1'b1, offered = 1'b0, fire = 1'b0;
    logic         seen0 = 1'b0, seen3 = 1'b0;
    logic [W-1:0] exp;
    for (int cyc = 0; cyc < 6000 && recv < 200; cyc++) begin
      @(negedge clk);
      if (fire) sent++;
      in_val3  = (sent < 200) && ($urandom_range(0, 9) < 6);
      in_msg3  = $urandom;
      out_rdy3 = ($urandom_range(0, 9) < 6);
      fire     = in_val3 && in_rdy3;
      if (fire) sb3.push_back(in_msg3);
      if (out_val3) begin
        if (!offered) begin
          wt = w - int'(idle_start);
          offered = 1'b1;
          checks++;
          if (wt < 0 || wt > 3) begin
            failures++;
            $display("FAIL rand_wait got=%0d exp=0..3", wt);
          end
          if (wt == 0) seen0 = 1'b1;
          if (wt == 3) seen3 = 1'b1;
        end
        if (out_rdy3) begin
          checks++;
          if (sb3.size() == 0) begin
            failures++;
            $display("FAIL rand_dup got=%h exp=none", out_msg3);
          end else begin
            exp = sb3.pop_front();
            if (out_msg3 !== exp) begin
              failures++;
              $display("FAIL rand_order got=%h exp=%h", out_msg3, exp);
            end
          end
          recv++;
          offered    = 1'b0;
          w          = 0;
          idle_start = 1'b0;
        end
      end else if (occ3 == 3'd0) begin
        idle_start = 1'b1;
        w          = 0;
      end else begin
        w++;
      end
    end
    @(negedge clk);
    in_val3  = 1'b0;
    out_rdy3 = 1'b0;
    checks++;
    if (recv != 200 || sent != 200 || sb3.size() != 0 || occ3 !== 3'd0) begin
      failures++;
      $display("FAIL rand_count got recv=%0d sent=%0d sb=%0d occ=%0d exp 200 200 0 0",
               recv, sent, sb3.size(), occ3);
    end
    checks++;
    if (!(seen0 && seen3)) begin
      failures++;
      $display("FAIL rand_wait_span got w0=%0b w3=%0b exp w0=1 w3=1", seen0, seen3);
    end
  endtask

  task automatic test_async_reset;
    logic         found = 1'b0, got = 1'b0;
    logic [W-1:0] exp;
    for (int a = 0; a < 20 && !found; a++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      out_rdy3 = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        in_val3 = 1'b1;
        in_msg3 = W'((k + 1) * 32'h11);
      end
      @(negedge clk);
      in_val3 = 1'b0;
      if (out_val3 === 1'b0 && occ3 === 3'd3) found = 1'b1;
      #2 reset = 1'b1;
      if (found) begin
        #1;
        checks++;
        if ({out_val3, in_rdy3, occ3, out_msg3} !== {1'b0, 1'b1, 3'd0, 32'd0}) begin
          failures++;
          $display("FAIL areset_now got val=%0b rdy=%0b occ=%0d msg=%h exp val=0 rdy=1 occ=0 msg=0",
                   out_val3, in_rdy3, occ3, out_msg3);
        end
      end
      @(negedge clk);
      reset = 1'b0;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL areset_midwait got=not_reached exp=reached");
    end
    sb3.delete();
    @(negedge clk);
    out_rdy3 = 1'b1;
    in_val3  = 1'b1;
    in_msg3  = 32'h0000_00AB;
    sb3.push_back(in_msg3);
    @(negedge clk);
    in_val3 = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (out_val3 === 1'b1) begin
        got = 1'b1;
        exp = sb3.pop_front();
        checks++;
        if (out_msg3 !== exp) begin
          failures++;
          $display("FAIL areset_after got=%h exp=%h", out_msg3, exp);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL areset_timeout got=no_output exp=000000ab");
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({out_val3, occ3} !== {1'b0, 3'd0}) begin
        failures++;
        $display("FAIL areset_stale got val=%0b occ=%0d msg=%h exp val=0 occ=0",
                 out_val3, occ3, out_msg3);
      end
      @(negedge clk);
    end
    out_rdy3 = 1'b0;
  endtask

  initial begin
    in_val0  = 1'b0;
    in_msg0  = '0;
    out_rdy0 = 1'b0;
    in_val3  = 1'b0;
    in_msg3  = '0;
    out_rdy3 = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vc_rand_delay_queue.md
# vc_rand_delay_queue

Elastic, order-preserving message queue with LFSR-driven random release delay. It is inserted on any val/rdy channel between the PARCv2 core and the test memory, on the request or response side, to stress the core's handshake and stall logic under variable latency. Each message is held at the queue head for a pseudo-random 0..p_max_delay cycles before being offered downstream. The core, memory and simulator harness are unchanged apart from instantiation.

## Interface
- p_msg_sz, 67, message width in bits (67 = 32-bit memory request, 35 = memory response)
- p_num_entries, 4, queue depth; power of two, 2..16
- p_max_delay, 0, maximum head-of-queue delay in cycles; 0..255
- p_seed, 16'hACE1, LFSR reset value; must be nonzero
- clk  input  1  clock; all state changes on posedge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_val  input  1  upstream message valid
- in_rdy  output  1  queue can accept a message
- in_msg  input  p_msg_sz  upstream message
- out_val  output  1  head message offered downstream
- out_rdy  input  1  downstream accepts the message
- out_msg  output  p_msg_sz  head message
- occupancy  output  clog2(p_num_entries)+1  number of stored entries

## Operation
- Storage: circular buffer of p_num_entries entries, with write pointer, read pointer and occupancy count. Pointers wrap modulo p_num_entries.
- Enqueue on in_val && in_rdy. in_rdy = (occupancy != p_num_entries). in_rdy has no full-bypass, so a full queue never enqueues, even when a dequeue happens in the same cycle.
- Dequeue on out_val && out_rdy. The read pointer advances.
- Simultaneous enqueue and dequeue leaves occupancy unchanged.
- LFSR: 16-bit Fibonacci register, taps 16,14,13,11. It shifts left every cycle with feedback into bit 0, reset value p_seed, and runs free regardless of traffic.
- Delay draw: d = lfsr[7:0] % (p_max_delay+1). An 8-bit down-counter holds the remaining delay.
- Head FSM, states IDLE, WAIT, SEND:
  - IDLE: if occupancy != 0, draw d. If d == 0, go to SEND; otherwise load counter = d and go to WAIT. If occupancy == 0, stay in IDLE.
  - WAIT: decrement the counter. When counter == 1, go to SEND.
  - SEND: out_val = 1. If out_rdy is low, stay in SEND.
  - SEND with out_rdy high: dequeue. If an entry remains (occupancy after dequeue != 0, counting any same-cycle enqueue), draw d: d == 0 stays in SEND, otherwise load the counter and go to WAIT. If no entry remains, go to IDLE.
- out_val = (state == SEND). It is registered state decode with no combinational path from in_val.
- out_msg always shows the buffer entry at the read pointer. It is valid only while out_val = 1.
- In SEND, out_msg and out_val hold stable until out_rdy is accepted.
- Messages leave in arrival order, without loss or duplication.
- Reset (asynchronous, any state, mid-transfer allowed):
  - state = IDLE, pointers = 0, occupancy = 0, counter = 0, lfsr = p_seed, storage = 0.
  - Outputs then read out_val = 0, in_rdy = 1, out_msg = 0, occupancy = 0.
  - Any held messages are discarded.

## Timing
- A handshake on edge t makes the entry visible (occupancy updated) after t.
- Empty queue, d == 0: IDLE transitions at edge t+1 and out_val = 1 during cycle t+1..t+2. Minimum in-to-out latency is 2 edges.
- Latency for delay d in an empty queue: 2 + d edges.
- p_max_delay = 0 with out_rdy held high gives sustained throughput of 1 message/cycle after the first.
- in_rdy falls in the cycle after the enqueue that fills the queue. It rises in the cycle after the dequeue that frees an entry.
- Zero-delay is handled without underflow: the counter is never loaded with 0.

## Test plan
- p_max_delay=0: enqueue 0x0000_1234 at edge 1 with out_rdy=1 -> out_val=1 and out_msg=0x0000_1234 after edge 2; dequeue at edge 3; occupancy returns to 0.
- p_max_delay=0, out_rdy=0: offer 5 messages 1..5 -> 4 accepted, in_rdy=0, occupancy=4. Raise out_rdy -> outputs 1,2,3,4 on consecutive cycles, then 5 is accepted and output.
- Backpressure: in SEND, hold out_rdy=0 for 10 cycles -> out_val stays 1 and out_msg is unchanged; occupancy is constant when no enqueue occurs.
- p_max_delay=3: 200 random messages with random in_val and out_rdy -> output order equals input order. Each head-wait is within 0..3 cycles, at least one wait of 0 and one of 3 occurs, and no message is lost.
- Reset asserted asynchronously mid-WAIT with 3 entries -> out_val=0, in_rdy=1, occupancy=0 immediately, without waiting for a clock edge. After release, new message 0xAB passes through and no stale entry appears.
- Inserted in front of the dual-port test memory response port in the simulator, running the PARCv2 assembly tests -> every test reports PASSED.
